sccb_cmd_arbiter: RTL and testbench

SCCB_CMD_ARBITER -- requirements
Module: sccb_cmd_arbiter

---
 rtl/sccb_cmd_arbiter_pkg.sv | 21 ++
 rtl/sccb_cmd_arbiter_rr_picker.sv | 29 ++
 rtl/sccb_cmd_arbiter.sv | 134 +++++++++++++
 tb/tb_sccb_cmd_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_cmd_arbiter_pkg.sv
// Shared types and constants for the SCCB command arbiter.
// The SCCB_ARB_TIMEOUT_EN macro enables the SEND watchdog.
package sccb_cmd_arbiter_pkg;

  localparam int CMD_W = 16;

  localparam logic [CMD_W-1:0] SCCB_SOFT_RESET_CMD = 16'h1280;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  function automatic logic is_soft_reset(
    input logic [CMD_W-1:0] cmd
  );
    return cmd == SCCB_SOFT_RESET_CMD;
  endfunction

endpackage

// File: rtl/sccb_cmd_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after
// last_grant, wrapping from N_REQ-1 back to 0.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    grant,
  output logic             any_valid
);

  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % N_REQ);
      if (req[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sccb_cmd_arbiter.sv
// Round-robin arbiter serialising register writes onto one SCCB sender.
// Define SCCB_ARB_TIMEOUT_EN to add a token watchdog in SEND.
module sccb_cmd_arbiter
  import sccb_cmd_arbiter_pkg::*;
#(
  parameter int N_REQ            = 4,
  parameter int GAP_CYCLES       = 16,
  parameter int RESET_GAP_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES   = 200000
) (
  input  logic                   ov7670_clk50,
  input  logic                   reg_conf_rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [CMD_W*N_REQ-1:0] req_cmd,
  output logic [N_REQ-1:0]       req_ack,
  output logic                   i2c_send,
  output logic [CMD_W-1:0]       i2c_cmd,
  input  logic                   token,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int GAP_MAX =
    (RESET_GAP_CYCLES > GAP_CYCLES) ?
    RESET_GAP_CYCLES : GAP_CYCLES;
  localparam int GW = $clog2(GAP_MAX + 1);
  localparam logic [GW-1:0] GAP_LD  = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] RGAP_LD = GW'(RESET_GAP_CYCLES);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("N_REQ must be in 2..8");
  end
  if (GAP_CYCLES < 0 || RESET_GAP_CYCLES < 0) begin : g_bad_gap
    $error("gap lengths must be non-negative");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end

  arb_state_t       state;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    grant;
  logic             any_valid;
  logic [GW-1:0]    gap_cnt;
  logic [CMD_W-1:0] grant_cmd;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  assign grant_cmd = req_cmd[CMD_W*int'(grant) +: CMD_W];
  assign busy      = (state != IDLE);

  // Ack is the grant itself, so it lands in the arbitration cycle.
  always_comb begin
    req_ack = '0;
    if (reg_conf_rst_n && state == IDLE && any_valid) begin
      req_ack[grant] = 1'b1;
    end
  end

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wdog_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge ov7670_clk50 or negedge reg_conf_rst_n) begin
    if (!reg_conf_rst_n) begin
      state      <= IDLE;
      i2c_send   <= 1'b0;
      i2c_cmd    <= '0;
      last_grant <= LAST_RST;
      gap_cnt    <= '0;
`ifdef SCCB_ARB_TIMEOUT_EN
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            i2c_cmd    <= grant_cmd;
            last_grant <= grant;
            i2c_send   <= 1'b1;
            state      <= SEND;
`ifdef SCCB_ARB_TIMEOUT_EN
            wdog_cnt   <= '0;
`endif
          end
        end
        SEND: begin
          if (token) begin
            i2c_send <= 1'b0;
            gap_cnt  <= is_soft_reset(i2c_cmd) ? RGAP_LD : GAP_LD;
            state    <= GAP;
`ifdef SCCB_ARB_TIMEOUT_EN
          end else if (wdog_cnt == TO_LAST) begin
            i2c_send    <= 1'b0;
            timeout_err <= 1'b1;
            gap_cnt     <= GAP_LD;
            state       <= GAP;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
`endif
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          i2c_send <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// Randomised bench for sccb_cmd_arbiter against a cycle-level model.
// Define SCCB_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_sccb_cmd_arbiter;

  localparam int NR  = 4;
  localparam int G   = 16;
  localparam int RG  = 50000;
  localparam int TO  = 100;

  logic              ov7670_clk50;
  logic              reg_conf_rst_n;
  logic [NR-1:0]     req_valid;
  logic [16*NR-1:0]  req_cmd;
  logic [NR-1:0]     req_ack;
  logic              i2c_send;
  logic [15:0]       i2c_cmd;
  logic              token;
  logic              busy;
  logic              timeout_err;

  sccb_cmd_arbiter #(
    .N_REQ            (NR),
    .GAP_CYCLES       (G),
    .RESET_GAP_CYCLES (RG),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .ov7670_clk50   (ov7670_clk50),
    .reg_conf_rst_n (reg_conf_rst_n),
    .req_valid      (req_valid),
    .req_cmd        (req_cmd),
    .req_ack        (req_ack),
    .i2c_send       (i2c_send),
    .i2c_cmd        (i2c_cmd),
    .token          (token),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  initial begin
    ov7670_clk50 = 1'b0;
    forever #5 ov7670_clk50 = ~ov7670_clk50;
  end

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_sending;
  int          m_gap;
  int          m_scnt;
  int          m_last;
  logic [15:0] m_cmd;
  bit          m_err;
  int          cyc;
  int          tok_time;
  int          grants[$];
  int          gtimes[$];

  // requester state
  bit          pend[NR];
  logic [15:0] pcmd[NR];
  bit          tok;
  int          auto_tok;
  bit          auto_repend;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h @%0d", tag, got, exp, cyc);
      if (errors >= 100) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v,
                                 input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_sending = 0;
    m_gap     = 0;
    m_scnt    = 0;
    m_last    = NR - 1;
    m_cmd     = '0;
    m_err     = 0;
  endtask

  task automatic step();
    logic [NR-1:0] v;
    logic [NR-1:0] eack;
    bit            ebusy;
    int            g;
    @(negedge ov7670_clk50);
    if (auto_tok >= 0 && m_sending && m_scnt == auto_tok) tok = 1;
    for (int i = 0; i < NR; i++) begin
      v[i] = pend[i];
      req_cmd[16*i +: 16] = pcmd[i];
    end
    req_valid = v;
    token     = tok;
    #1;
    ebusy = m_sending || (m_gap > 0);
    eack  = '0;
    g     = -1;
    if (!ebusy) begin
      g = rr_pick(v, m_last);
      if (g >= 0) eack[g] = 1'b1;
    end
    chk("ack",  req_ack,     eack);
    chk("busy", busy,        ebusy);
    chk("send", i2c_send,    m_sending);
    chk("cmd",  i2c_cmd,     m_cmd);
    chk("terr", timeout_err, m_err);
    if (g >= 0) begin
      m_cmd     = pcmd[g];
      m_last    = g;
      m_sending = 1;
      m_scnt    = 0;
      grants.push_back(g);
      gtimes.push_back(cyc);
      pend[g] = 0;
      if (auto_repend) begin
        pend[g] = 1;
        pcmd[g] = {8'(g + 1), 8'(cyc)};
      end
    end else if (m_sending) begin
      if (tok) begin
        m_sending = 0;
        m_gap     = ((m_cmd == 16'h1280) ? RG : G) + 1;
        tok_time  = cyc;
      end else begin
        m_scnt++;
`ifdef SCCB_ARB_TIMEOUT_EN
        if (m_scnt == TO) begin
          m_sending = 0;
          m_err     = 1;
          m_gap     = G + 1;
        end
`endif
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end
    tok = 0;
    cyc++;
  endtask

  task automatic run_until_grant(input int budget);
    int n0;
    n0 = grants.size();
    for (int i = 0; i < budget; i++) begin
      step();
      if (grants.size() > n0) return;
    end
    chk("grant_wait", grants.size(), n0 + 1);
  endtask

  task automatic drain();
    for (int i = 0; i < NR; i++) pend[i] = 0;
    auto_repend = 0;
    auto_tok    = 1;
    for (int i = 0; i < 60000; i++) begin
      step();
      if (!m_sending && m_gap == 0) break;
    end
    step();
    chk("drain_idle", busy, 0);
  endtask

  int n0;
  int sc;

  initial begin
    reg_conf_rst_n = 1'b0;
    req_valid      = '0;
    req_cmd        = '0;
    token          = 1'b0;
    tok            = 0;
    auto_tok       = -1;
    auto_repend    = 0;
    cyc            = 0;
    tok_time       = -1;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 0;
      pcmd[i] = '0;
    end
    model_reset();

    #22;
    chk("rst_send", i2c_send, 0);
    chk("rst_cmd",  i2c_cmd,  0);
    chk("rst_ack",  req_ack,  0);
    chk("rst_busy", busy,     0);
    chk("rst_terr", timeout_err, 0);
    #5 reg_conf_rst_n = 1'b1;

    // all four continuously requesting from reset
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1;
      pcmd[i] = {8'h20 + 8'(i), 8'h55};
    end
    auto_repend = 1;
    auto_tok    = 2;
    for (int n = 0; n < 5; n++) run_until_grant(100);
    chk("order0", grants[0], 0);
    chk("order1", grants[1], 1);
    chk("order2", grants[2], 2);
    chk("order3", grants[3], 3);
    chk("order4", grants[4], 0);
    drain();

    // single requester cadence, then a second joins
    pend[0] = 1;
    pcmd[0] = 16'h0a0b;
    auto_repend = 1;
    auto_tok    = 3;
    n0 = grants.size();
    for (int n = 0; n < 4; n++) run_until_grant(100);
    for (int n = 1; n < 4; n++)
      chk("period", gtimes[n0+n] - gtimes[n0+n-1], G + 4 + 2);
    pend[3] = 1;
    pcmd[3] = 16'h3c3d;
    run_until_grant(100);
    chk("no_starve", grants[$], 3);
    drain();

    // single request with fixed command
    pend[0] = 1;
    pcmd[0] = 16'h1204;
    auto_tok = 2;
    run_until_grant(20);
    chk("ack0", req_ack, 4'b0001);
    step();
    chk("send_on",  i2c_send, 1);
    chk("cmd_1204", i2c_cmd,  16'h1204);
    drain();

    // token while idle is ignored
    tok = 1;
    step();
    step();
    chk("idle_tok", busy, 0);

    // soft reset command stretches the gap
    pend[1] = 1;
    pcmd[1] = 16'h1280;
    auto_tok = 1;
    tok_time = -1;
    run_until_grant(20);
    for (int i = 0; i < 10 && tok_time < 0; i++) step();
    chk("srst_tok", tok_time >= 0, 1);
    pend[2] = 1;
    pcmd[2] = 16'h3344;
    run_until_grant(RG + 100);
    chk("srst_gap", (gtimes[$] - tok_time) >= RG, 1);
    chk("srst_next", grants[$], 2);
    drain();

    // reset asserted in the middle of a transfer
    for (int i = 0; i < NR; i++) pend[i] = 1;
    auto_tok = -1;
    run_until_grant(30);
    step();
    chk("pre_rst_send", i2c_send, 1);
    #2 reg_conf_rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) pend[i] = 1;
    chk("mid_rst_send", i2c_send, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack",  req_ack, 0);
    chk("mid_rst_cmd",  i2c_cmd, 0);
    chk("mid_rst_terr", timeout_err, 0);
    model_reset();
    @(posedge ov7670_clk50);
    #2 reg_conf_rst_n = 1'b1;
    run_until_grant(10);
    chk("rst_grant0", grants[$], 0);
    drain();

`ifdef SCCB_ARB_TIMEOUT_EN
    // watchdog fires with no token
    pend[2] = 1;
    pcmd[2] = 16'h4455;
    auto_tok = -1;
    run_until_grant(20);
    sc = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i2c_send) sc++;
      else if (sc > 0) break;
    end
    chk("to_len", sc, TO);
    chk("to_err", timeout_err, 1);
    drain();
    pend[1] = 1;
    pcmd[1] = 16'h6677;
    run_until_grant(20);
    drain();
    chk("to_sticky", timeout_err, 1);
`endif

    // random traffic, withdrawals and stray tokens
    auto_tok = -1;
    auto_repend = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(99) < 15) begin
          pend[i] = 1;
          pcmd[i] = 16'($urandom);
          if (pcmd[i] == 16'h1280) pcmd[i] = 16'h1281;
        end else if (pend[i] && $urandom_range(99) < 3) begin
          pend[i] = 0;
        end
      end
      tok = ($urandom_range(99) < 20);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
